// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state codes and grant ids for the cache/memory arbiter.
// Optional feature macro: MEM_ARB_RR_EN (round-robin grant on simultaneous requests).
package mem_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] TURN   = 2'd3;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant selection between the I-cache and D-cache requests.
// With MEM_ARB_RR_EN defined a tie goes to the requester not granted last time.
module mem_arb_sel
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_d
);

  gnt_t sel;

`ifndef MEM_ARB_RR_EN
  // Fixed priority never looks at the previous winner.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    sel = GNT_I;
    if (req_d && req_i) begin
`ifdef MEM_ARB_RR_EN
      sel = (last_grant == GNT_D) ? GNT_I : GNT_D;
`else
      sel = GNT_D;
`endif
    end else if (req_d) begin
      sel = GNT_D;
    end
  end

  assign gnt_valid = req_i | req_d;
  assign gnt_d     = (sel == GNT_D);

endmodule

// File: rtl/mem_arbiter.sv
// Two-cache to single memory port arbiter: registered request forwarding, ready/rdata routing.
// Optional feature macro: MEM_ARB_RR_EN (round-robin tie break with a last_grant register).
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              icache_read,
  input  logic              icache_write,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic [DATA_W-1:0] icache_wdata,
  output logic [DATA_W-1:0] icache_rdata,
  output logic              icache_ready,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic              dcache_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  logic [1:0]        state_q, state_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              gnt_valid;
  logic              gnt_d;
  logic              last_grant;

`ifdef MEM_ARB_RR_EN
  logic last_grant_q, last_grant_d;
  assign last_grant = last_grant_q;
`else
  assign last_grant = GNT_I;
`endif

  mem_arb_sel u_sel (
    .req_i      (icache_read | icache_write),
    .req_d      (dcache_read | dcache_write),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_d      (gnt_d)
  );

  // A write wins over a simultaneous read from the same cache.
  always_comb begin
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef MEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt_d) begin
            mem_write_d = dcache_write;
            mem_read_d  = dcache_read & ~dcache_write;
            mem_addr_d  = dcache_addr;
            mem_wdata_d = dcache_wdata;
            state_d     = BUSY_D;
          end else begin
            mem_write_d = icache_write;
            mem_read_d  = icache_read & ~icache_write;
            mem_addr_d  = icache_addr;
            mem_wdata_d = icache_wdata;
            state_d     = BUSY_I;
          end
`ifdef MEM_ARB_RR_EN
          last_grant_d = gnt_d ? GNT_D : GNT_I;
`endif
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = TURN;
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= GNT_I;
`endif
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef MEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Responses reach only the cache whose transaction is in flight.
  assign icache_ready = (state_q == BUSY_I) & mem_ready;
  assign dcache_ready = (state_q == BUSY_D) & mem_ready;
  assign icache_rdata = (state_q == BUSY_I) ? mem_rdata : '0;
  assign dcache_rdata = (state_q == BUSY_D) ? mem_rdata : '0;

  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand-written multi-cycle sequences.
// Build with MEM_ARB_RR_EN defined to check the round-robin grant order instead of fixed priority.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic              clk;
  logic              proc_reset;
  logic              icache_read, icache_write;
  logic [ADDR_W-1:0] icache_addr;
  logic [DATA_W-1:0] icache_wdata, icache_rdata;
  logic              icache_ready;
  logic              dcache_read, dcache_write;
  logic [ADDR_W-1:0] dcache_addr;
  logic [DATA_W-1:0] dcache_wdata, dcache_rdata;
  logic              dcache_ready;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_ready;

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  typedef struct {
    logic              dr, dw;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dwdata;
    logic              ir, iw;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] iwdata;
    int                lat;
    logic [DATA_W-1:0] rdata;
    logic              exp_d;
    logic              exp_write;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
  } vec_t;

  txn_t exp_q[$];
  txn_t mon_e;
  vec_t vecs[6];
  logic prev_active;
  int   vec_count = 0;
  int   miscompares = 0;

  mem_arbiter dut (
    .clk          (clk),
    .proc_reset   (proc_reset),
    .icache_read  (icache_read),
    .icache_write (icache_write),
    .icache_addr  (icache_addr),
    .icache_wdata (icache_wdata),
    .icache_rdata (icache_rdata),
    .icache_ready (icache_ready),
    .dcache_read  (dcache_read),
    .dcache_write (dcache_write),
    .dcache_addr  (dcache_addr),
    .dcache_wdata (dcache_wdata),
    .dcache_rdata (dcache_rdata),
    .dcache_ready (dcache_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                             input logic [DATA_W-1:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearRequests();
    icache_read  = 1'b0;
    icache_write = 1'b0;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
  endtask

  task automatic pushExp(input logic write, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata);
    txn_t t;
    t.write = write;
    t.addr  = addr;
    t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  task automatic applyStimulus(input vec_t v);
    dcache_read  = v.dr;
    dcache_write = v.dw;
    dcache_addr  = v.daddr;
    dcache_wdata = v.dwdata;
    icache_read  = v.ir;
    icache_write = v.iw;
    icache_addr  = v.iaddr;
    icache_wdata = v.iwdata;
    pushExp(v.exp_write, v.exp_addr, v.exp_wdata);
  endtask

  // Memory responder: answers the in-flight transaction after lat cycles, leaves the DUT in TURN.
  task automatic serveTxn(input int lat, input logic [DATA_W-1:0] rdata,
                          input logic exp_d, input string tag);
    int k = 0;
    while (!(mem_read || mem_write) && k < 20) begin
      tick();
      k++;
    end
    checkOutput({tag, "_active"}, DATA_W'(mem_read | mem_write), 1);
    if (!(mem_read || mem_write)) return;
    repeat (lat - 1) tick();
    mem_rdata = rdata;
    mem_ready = 1'b1;
    #1;
    checkOutput({tag, "_ready"},       DATA_W'(exp_d ? dcache_ready : icache_ready), 1);
    checkOutput({tag, "_other_ready"}, DATA_W'(exp_d ? icache_ready : dcache_ready), 0);
    checkOutput({tag, "_rdata"},       exp_d ? dcache_rdata : icache_rdata, rdata);
    checkOutput({tag, "_other_rdata"}, exp_d ? icache_rdata : dcache_rdata, 0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput({tag, "_turn_idle"}, DATA_W'(mem_read | mem_write), 0);
  endtask

  // Scoreboard: every new memory transaction must match the next expected one.
  always @(negedge clk) begin
    if ((mem_read || mem_write) && !prev_active) begin
      checkOutput("sb_nonempty", DATA_W'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_write", DATA_W'(mem_write), DATA_W'(mon_e.write));
        checkOutput("sb_read",  DATA_W'(mem_read),  DATA_W'(!mon_e.write));
        checkOutput("sb_addr",  DATA_W'(mem_addr),  DATA_W'(mon_e.addr));
        checkOutput("sb_wdata", mem_wdata, mon_e.wdata);
      end
    end
    if (mem_read || mem_write) checkOutput("rw_exclusive", DATA_W'(mem_read & mem_write), 0);
    prev_active = mem_read || mem_write;
  end

  initial begin
    logic prio_d[4];
`ifdef MEM_ARB_RR_EN
    prio_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    prio_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    // {dr,dw,daddr,dwdata, ir,iw,iaddr,iwdata, lat,rdata, exp_d,exp_write,exp_addr,exp_wdata}
    vecs[0] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b0, 28'h0000010, 128'h0,
                5, {16{8'hA5}}, 1'b0, 1'b0, 28'h0000010, 128'h0};
    vecs[1] = '{1'b1, 1'b0, 28'h1234567, 128'h0, 1'b0, 1'b0, 28'h0, 128'h0,
                3, {4{32'h5A5A_0F0F}}, 1'b1, 1'b0, 28'h1234567, 128'h0};
    vecs[2] = '{1'b0, 1'b1, 28'h0000040, {4{32'hDEAD_BEEF}}, 1'b0, 1'b0, 28'h0, 128'h0,
                1, 128'h77, 1'b1, 1'b1, 28'h0000040, {4{32'hDEAD_BEEF}}};
    vecs[3] = '{1'b1, 1'b1, 28'h0000080, 128'hBEEF, 1'b0, 1'b0, 28'h0, 128'h0,
                2, 128'h0, 1'b1, 1'b1, 28'h0000080, 128'hBEEF};
    vecs[4] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b0, 1'b1, 28'hFFFFFFF, {128{1'b1}},
                2, 128'h3, 1'b0, 1'b1, 28'hFFFFFFF, {128{1'b1}}};
    vecs[5] = '{1'b0, 1'b0, 28'h0, 128'h0, 1'b1, 1'b1, 28'h0000000, 128'h1,
                1, 128'h9, 1'b0, 1'b1, 28'h0000000, 128'h1};

    prev_active  = 1'b0;
    proc_reset   = 1'b1;
    clearRequests();
    icache_addr  = '0;
    icache_wdata = '0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    tick();
    tick();
    proc_reset = 1'b0;

    checkOutput("rst_mem_read",  DATA_W'(mem_read), 0);
    checkOutput("rst_mem_write", DATA_W'(mem_write), 0);
    checkOutput("rst_mem_addr",  DATA_W'(mem_addr), 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    mem_ready = 1'b1;
    mem_rdata = 128'h55;
    #1;
    checkOutput("spurious_i_ready", DATA_W'(icache_ready), 0);
    checkOutput("spurious_d_ready", DATA_W'(dcache_ready), 0);
    checkOutput("spurious_i_rdata", icache_rdata, 0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    checkOutput("spurious_no_txn", DATA_W'(mem_read | mem_write), 0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      tick();
      serveTxn(vecs[i].lat, vecs[i].rdata, vecs[i].exp_d, $sformatf("vec%0d", i));
      clearRequests();
      tick();
    end

    // Simultaneous requests: D write first, one dead cycle, then the I read.
    dcache_write = 1'b1;
    dcache_addr  = 28'h0000020;
    dcache_wdata = 128'h1234;
    icache_read  = 1'b1;
    icache_addr  = 28'h0000030;
    icache_wdata = '0;
    pushExp(1'b1, 28'h0000020, 128'h1234);
    pushExp(1'b0, 28'h0000030, 128'h0);
    tick();
    serveTxn(2, 128'h0, 1'b1, "simD");
    dcache_write = 1'b0;
    tick();
    checkOutput("sim_idle_read", DATA_W'(mem_read), 0);
    tick();
    checkOutput("simI_addr", DATA_W'(mem_addr), DATA_W'(28'h0000030));
    serveTxn(2, {4{32'hCAFE_F00D}}, 1'b0, "simI");
    clearRequests();
    tick();

    // Write-back then refill requested in the TURN cycle.
    dcache_write = 1'b1;
    dcache_addr  = 28'h0000040;
    dcache_wdata = {4{32'h0BAD_F00D}};
    pushExp(1'b1, 28'h0000040, {4{32'h0BAD_F00D}});
    tick();
    serveTxn(1, 128'h0, 1'b1, "wb");
    dcache_write = 1'b0;
    dcache_read  = 1'b1;
    dcache_addr  = 28'h0000050;
    dcache_wdata = '0;
    pushExp(1'b0, 28'h0000050, 128'h0);
    checkOutput("wb_write_dropped", DATA_W'(mem_write), 0);
    tick();
    tick();
    checkOutput("refill_addr", DATA_W'(mem_addr), DATA_W'(28'h0000050));
    serveTxn(2, {8{16'h1357}}, 1'b1, "refill");
    clearRequests();
    tick();

    // Address change while in flight is ignored.
    dcache_read = 1'b1;
    dcache_addr = 28'h0000060;
    pushExp(1'b0, 28'h0000060, 128'h0);
    tick();
    dcache_addr = 28'h0000070;
    tick();
    tick();
    checkOutput("hold_addr", DATA_W'(mem_addr), DATA_W'(28'h0000060));
    serveTxn(1, 128'h42, 1'b1, "hold");
    clearRequests();
    tick();

    // Reset during BUSY_I abandons the transaction.
    icache_read = 1'b1;
    icache_addr = 28'h0000090;
    pushExp(1'b0, 28'h0000090, 128'h0);
    tick();
    checkOutput("busyI_read", DATA_W'(mem_read), 1);
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    clearRequests();
    checkOutput("rstmid_read", DATA_W'(mem_read), 0);
    checkOutput("rstmid_addr", DATA_W'(mem_addr), 0);
    mem_ready = 1'b1;
    #1;
    checkOutput("rstmid_i_ready", DATA_W'(icache_ready), 0);
    tick();
    mem_ready = 1'b0;
    checkOutput("rstmid_no_regrant", DATA_W'(mem_read | mem_write), 0);

    // Both caches requesting continuously for four transactions.
    proc_reset = 1'b1;
    tick();
    proc_reset = 1'b0;
    dcache_read = 1'b1;
    dcache_addr = 28'h0000100;
    icache_read = 1'b1;
    icache_addr = 28'h0000200;
    for (int n = 0; n < 4; n++) begin
      pushExp(1'b0, prio_d[n] ? 28'h0000100 : 28'h0000200, 128'h0);
      tick();
      serveTxn(1, DATA_W'(n + 1), prio_d[n], $sformatf("prio%0d", n));
      if (n == 3) clearRequests();
      tick();
    end

    tick();
    checkOutput("sb_drained", DATA_W'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
